// File: rtl/ddr_read_arbiter.sv
// Two-requester round-robin read arbiter in front of a DDR address FIFO.
// A tag queue remembers who issued each read so returning beats are routed back.
module ddr_read_arbiter #(
  parameter int TAG_DEPTH = 4,
  parameter int BEATS     = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_r0_valid,
  input  logic [30:0]  i_r0_addr,
  input  logic         i_r1_valid,
  input  logic [30:0]  i_r1_addr,
  output logic         o_r0_ack,
  output logic         o_r1_ack,
  input  logic         i_af_full,
  output logic         o_af_wr_en,
  output logic [30:0]  o_af_addr_din,
  input  logic         i_rdf_valid,
  input  logic [127:0] i_rdf_dout,
  output logic         o_rdf_rd_en,
  output logic [127:0] o_rd_data,
  output logic         o_r0_rd_valid,
  output logic         o_r1_rd_valid,
  output logic         o_busy,
  output logic         o_rdf_orphan
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                 r_state;
  logic [30:0]            r_addr;
  logic                   r_id;
  logic                   r_last;
  logic [TAG_DEPTH-1:0]   r_tags;
  logic [PW-1:0]          r_wptr;
  logic [PW-1:0]          r_rptr;
  logic [PW:0]            r_count;
  logic [BW-1:0]          r_beat;
  logic                   r_orphan;

  logic w_full;
  logic w_empty;
  logic w_winner;
  logic w_push;
  logic w_pop;
  logic w_head;

  assign w_full   = (r_count == (PW+1)'(TAG_DEPTH));
  assign w_empty  = (r_count == '0);
  // With both requesting, the one not granted last wins; otherwise the only one asking.
  assign w_winner = (i_r0_valid && i_r1_valid) ? ~r_last : i_r1_valid;
  assign w_head   = r_tags[r_rptr];

  assign o_af_wr_en    = (r_state == ISSUE) && !i_af_full;
  assign o_af_addr_din = r_addr;
  assign w_push        = o_af_wr_en;
  assign o_r0_ack      = w_push && !r_id;
  assign o_r1_ack      = w_push && r_id;

  assign o_rdf_rd_en   = i_rdf_valid && !w_empty;
  assign w_pop         = o_rdf_rd_en && (r_beat == BW'(BEATS-1));
  assign o_rd_data     = i_rdf_dout;
  assign o_r0_rd_valid = o_rdf_rd_en && !w_head;
  assign o_r1_rd_valid = o_rdf_rd_en && w_head;

  assign o_busy        = (r_state == ISSUE) || !w_empty;
  assign o_rdf_orphan  = r_orphan;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_id     <= 1'b0;
      r_last   <= 1'b1;
      r_tags   <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_beat   <= '0;
      r_orphan <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_full && (i_r0_valid || i_r1_valid)) begin
            r_state <= ISSUE;
            r_id    <= w_winner;
            r_addr  <= w_winner ? i_r1_addr : i_r0_addr;
          end
        end
        ISSUE: begin
          if (!i_af_full) begin
            r_state <= IDLE;
            r_last  <= r_id;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_push) begin
        r_tags[r_wptr] <= r_id;
        r_wptr         <= r_wptr + 1'b1;
      end

      if (o_rdf_rd_en) begin
        r_beat <= w_pop ? '0 : r_beat + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // Data arriving with nothing outstanding means the DDR side and the tag queue disagree.
      if (i_rdf_valid && w_empty) begin
        r_orphan <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ddr_read_arbiter.sv
// Directed self-checking bench for ddr_read_arbiter: grant order, backpressure,
// queue-full stall, beat routing, orphan detection and reset behaviour.
module tb_ddr_read_arbiter;

  logic         clk;
  logic         rst_n;
  logic         r0_valid;
  logic [30:0]  r0_addr;
  logic         r1_valid;
  logic [30:0]  r1_addr;
  logic         r0_ack;
  logic         r1_ack;
  logic         af_full;
  logic         af_wr_en;
  logic [30:0]  af_addr_din;
  logic         rdf_valid;
  logic [127:0] rdf_dout;
  logic         rdf_rd_en;
  logic [127:0] rd_data;
  logic         r0_rd_valid;
  logic         r1_rd_valid;
  logic         busy;
  logic         rdf_orphan;

  int nChecks;
  int nFails;

  ddr_read_arbiter #(.TAG_DEPTH(4), .BEATS(2)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_r0_valid    (r0_valid),
    .i_r0_addr     (r0_addr),
    .i_r1_valid    (r1_valid),
    .i_r1_addr     (r1_addr),
    .o_r0_ack      (r0_ack),
    .o_r1_ack      (r1_ack),
    .i_af_full     (af_full),
    .o_af_wr_en    (af_wr_en),
    .o_af_addr_din (af_addr_din),
    .i_rdf_valid   (rdf_valid),
    .i_rdf_dout    (rdf_dout),
    .o_rdf_rd_en   (rdf_rd_en),
    .o_rd_data     (rd_data),
    .o_r0_rd_valid (r0_rd_valid),
    .o_r1_rd_valid (r1_rd_valid),
    .o_busy        (busy),
    .o_rdf_orphan  (rdf_orphan)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one rdf beat for a cycle and checks where it is routed.
  task automatic applyBeat(input string tag, input logic [127:0] d, input logic who);
    rdf_valid = 1'b1;
    rdf_dout  = d;
    #1;
    checkOutput({tag, "_rd_en"}, rdf_rd_en, 1'b1);
    checkOutput({tag, "_r0_rdv"}, r0_rd_valid, !who);
    checkOutput({tag, "_r1_rdv"}, r1_rd_valid, who);
    checkOutput({tag, "_data"}, rd_data, d);
    @(negedge clk);
  endtask

  // Issues one request from a single requester, expecting the ack one cycle later.
  task automatic applyStimulus(input string tag, input logic who, input logic [30:0] addr);
    if (who) begin r1_valid = 1'b1; r1_addr = addr; end
    else     begin r0_valid = 1'b1; r0_addr = addr; end
    @(negedge clk);
    #1;
    checkOutput({tag, "_wr_en"}, af_wr_en, 1'b1);
    checkOutput({tag, "_addr"}, af_addr_din, addr);
    checkOutput({tag, "_ack0"}, r0_ack, !who);
    checkOutput({tag, "_ack1"}, r1_ack, who);
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    @(negedge clk);
  endtask

  logic [30:0]  contAddr [4];
  logic [127:0] beatA;
  logic         seenAck;

  initial begin
    nChecks   = 0;
    nFails    = 0;
    rst_n     = 1'b0;
    r0_valid  = 1'b0;
    r0_addr   = '0;
    r1_valid  = 1'b0;
    r1_addr   = '0;
    af_full   = 1'b0;
    rdf_valid = 1'b0;
    rdf_dout  = '0;
    contAddr  = '{31'h0000_1000, 31'h0100_0000, 31'h0000_2000, 31'h0200_0000};
    beatA     = 128'hff000000ceaa0e3ddeadbeefffffffff;

    #3;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_orphan", rdf_orphan, 1'b0);
    checkOutput("rst_wr_en", af_wr_en, 1'b0);
    checkOutput("rst_ack0", r0_ack, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention: both held valid, grants alternate starting with r0.
    r0_valid = 1'b1; r0_addr = contAddr[0];
    r1_valid = 1'b1; r1_addr = contAddr[1];
    for (int g = 0; g < 4; g++) begin
      #1;
      checkOutput($sformatf("cont%0d_idle", g), af_wr_en, 1'b0);
      @(negedge clk);
      #1;
      checkOutput($sformatf("cont%0d_ack0", g), r0_ack, (g % 2) == 0);
      checkOutput($sformatf("cont%0d_ack1", g), r1_ack, (g % 2) == 1);
      checkOutput($sformatf("cont%0d_addr", g), af_addr_din, contAddr[g]);
      if (g == 0) r0_addr = contAddr[2];
      if (g == 1) r1_addr = contAddr[3];
      if (g == 3) begin r0_valid = 1'b0; r1_valid = 1'b0; end
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      applyBeat($sformatf("cont_beat%0d", i), {4{32'hcafe_0000}} + 128'(i), ((i / 2) % 2) == 1);
    end
    rdf_valid = 1'b0;
    #1;
    checkOutput("cont_busy_end", busy, 1'b0);
    @(negedge clk);

    // Single r0 read with two returned beats.
    r0_valid = 1'b1;
    r0_addr  = 31'h10400000;
    #1;
    checkOutput("single_idle_wr", af_wr_en, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("single_wr_en", af_wr_en, 1'b1);
    checkOutput("single_addr", af_addr_din, 31'h10400000);
    checkOutput("single_ack0", r0_ack, 1'b1);
    checkOutput("single_ack1", r1_ack, 1'b0);
    checkOutput("single_busy", busy, 1'b1);
    r0_valid = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("single_wr_after", af_wr_en, 1'b0);
    checkOutput("single_busy_out", busy, 1'b1);
    applyBeat("single_b0", beatA, 1'b0);
    applyBeat("single_b1", 128'h0, 1'b0);
    rdf_valid = 1'b0;
    #1;
    checkOutput("single_busy_end", busy, 1'b0);
    checkOutput("single_rd_en_end", rdf_rd_en, 1'b0);
    @(negedge clk);

    // Backpressure: af_full held for five ISSUE cycles.
    r1_valid = 1'b1;
    r1_addr  = 31'h0abc_def0;
    af_full  = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput($sformatf("bp%0d_wr_en", c), af_wr_en, 1'b0);
      checkOutput($sformatf("bp%0d_addr", c), af_addr_din, 31'h0abc_def0);
      checkOutput($sformatf("bp%0d_ack1", c), r1_ack, 1'b0);
      @(negedge clk);
    end
    af_full = 1'b0;
    #1;
    checkOutput("bp_wr_en", af_wr_en, 1'b1);
    checkOutput("bp_ack1", r1_ack, 1'b1);
    checkOutput("bp_addr", af_addr_din, 31'h0abc_def0);
    r1_valid = 1'b0;
    @(negedge clk);
    applyBeat("bp_b0", 128'h1, 1'b1);
    applyBeat("bp_b1", 128'h2, 1'b1);
    rdf_valid = 1'b0;

    // Queue full: four outstanding, the fifth waits until one read completes.
    for (int k = 0; k < 4; k++) begin
      applyStimulus($sformatf("full_req%0d", k), 1'b0, 31'h0000_0100 + 31'(k));
    end
    r1_valid = 1'b1;
    r1_addr  = 31'h7000_0000;
    for (int c = 0; c < 6; c++) begin
      #1;
      checkOutput($sformatf("full_stall%0d_ack", c), r1_ack, 1'b0);
      checkOutput($sformatf("full_stall%0d_wr", c), af_wr_en, 1'b0);
      @(negedge clk);
    end
    applyBeat("full_b0", 128'h10, 1'b0);
    applyBeat("full_b1", 128'h11, 1'b0);
    rdf_valid = 1'b0;
    seenAck   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (r1_ack) begin
        seenAck = 1'b1;
        checkOutput("full_5th_addr", af_addr_din, 31'h7000_0000);
        r1_valid = 1'b0;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    checkOutput("full_5th_acked", seenAck, 1'b1);
    r1_valid = 1'b0;

    // Reset with three outstanding and the head mid-burst.
    applyBeat("rst_pre_b0", 128'h20, 1'b0);
    applyBeat("rst_pre_b1", 128'h21, 1'b0);
    applyBeat("rst_pre_b2", 128'h22, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_busy", busy, 1'b0);
    checkOutput("rstmid_rd_en", rdf_rd_en, 1'b0);
    checkOutput("rstmid_r0_rdv", r0_rd_valid, 1'b0);
    checkOutput("rstmid_orphan", rdf_orphan, 1'b0);
    rdf_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    r0_valid = 1'b1; r0_addr = 31'h0000_0d00;
    r1_valid = 1'b1; r1_addr = 31'h0000_0e00;
    @(negedge clk);
    #1;
    checkOutput("post_rst_ack0", r0_ack, 1'b1);
    checkOutput("post_rst_ack1", r1_ack, 1'b0);
    checkOutput("post_rst_addr", af_addr_din, 31'h0000_0d00);
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    @(negedge clk);
    applyBeat("post_rst_b0", 128'h30, 1'b0);
    #1;
    checkOutput("post_rst_mid_busy", busy, 1'b1);
    applyBeat("post_rst_b1", 128'h31, 1'b0);
    rdf_valid = 1'b0;
    #1;
    checkOutput("post_rst_busy", busy, 1'b0);
    @(negedge clk);

    // Orphan data with an empty tag queue.
    rdf_valid = 1'b1;
    rdf_dout  = 128'hdead;
    #1;
    checkOutput("orph_rd_en", rdf_rd_en, 1'b0);
    checkOutput("orph_r0_rdv", r0_rd_valid, 1'b0);
    checkOutput("orph_r1_rdv", r1_rd_valid, 1'b0);
    checkOutput("orph_pre", rdf_orphan, 1'b0);
    @(negedge clk);
    rdf_valid = 1'b0;
    #1;
    checkOutput("orph_set", rdf_orphan, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("orph_sticky", rdf_orphan, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("orph_clear", rdf_orphan, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/ddr_read_arbiter.md
DDR_READ_ARBITER -- requirements
Module: ddr_read_arbiter

Interface
REQ-001 SHALL have parameter TAG_DEPTH, default 4, giving the maximum number of outstanding read requests (power of two, 2..16).
REQ-002 SHALL have parameter BEATS, default 2, giving the number of 128-bit rdf beats returned per request.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports r0_valid/r1_valid  input  1  read request from requester 0 (GP command FIFO) / 1 (pixel feeder).
REQ-006 SHALL have ports r0_addr/r1_addr  input  31  request address, passed unmodified to af_addr_din.
REQ-007 SHALL have ports r0_ack/r1_ack  output  1  one-cycle pulse: request accepted into the address FIFO.
REQ-008 SHALL have ports af_full  input  1; af_wr_en  output  1; af_addr_din  output  31  DDR address FIFO write side.
REQ-009 SHALL have ports rdf_valid  input  1; rdf_dout  input  128; rdf_rd_en  output  1  DDR read-data FIFO read side.
REQ-010 SHALL have ports rd_data  output  128  rdf_dout passthrough; r0_rd_valid/r1_rd_valid  output  1  beat belongs to requester 0/1.
REQ-011 SHALL have ports busy  output  1  any request outstanding or in ISSUE; rdf_orphan  output  1  sticky error flag.

Function
REQ-012 SHALL implement the issue FSM with states IDLE and ISSUE.
REQ-013 In IDLE, with at least one rN_valid high and tag queue not full, SHALL select a winner, latch its address and id, and enter ISSUE next cycle.
REQ-014 Selection SHALL be round-robin: with both valid, the requester not granted last wins; after reset requester 0 has priority.
REQ-015 In IDLE with tag queue full, SHALL not select a winner and SHALL remain in IDLE.
REQ-016 In ISSUE, af_wr_en SHALL equal !af_full (combinational), af_addr_din SHALL hold the latched address, and af_wr_en SHALL be 0 in IDLE.
REQ-017 On the cycle af_wr_en=1: winner's rN_ack SHALL pulse high for exactly that cycle, the winner id SHALL be pushed into the tag queue, the last-granted pointer SHALL update, and the FSM SHALL return to IDLE.
REQ-018 While af_full=1 in ISSUE, SHALL remain in ISSUE with the address stable; requesters SHALL hold rN_valid/rN_addr until rN_ack.
REQ-019 Issue throughput SHALL be at most one request per 2 cycles; issue latency from rN_valid (IDLE, not full, af_full=0) to rN_ack SHALL be 1 cycle.
REQ-020 rdf_rd_en SHALL equal rdf_valid AND tag queue not empty (combinational); requesters always accept data.
REQ-021 When rdf_rd_en=1, rN_rd_valid SHALL be high for the requester at the tag-queue head only; rd_data SHALL equal rdf_dout.
REQ-022 A beat counter (0..BEATS-1) SHALL increment on each rdf_rd_en; on the beat with count BEATS-1 it SHALL wrap to 0 and the tag-queue head SHALL pop.
REQ-023 Simultaneous push (REQ-017) and pop (REQ-022) SHALL leave occupancy unchanged; full is computed on current occupancy, so a pop in the same cycle does not enable a select.
REQ-024 Tag-queue read/write pointers SHALL wrap modulo TAG_DEPTH.
REQ-025 rdf_valid=1 with tag queue empty SHALL set rdf_orphan (sticky until reset), SHALL NOT assert rdf_rd_en, and SHALL NOT assert any rN_rd_valid.
REQ-026 busy SHALL be high when the FSM is in ISSUE or the tag queue is not empty.

Reset
REQ-027 On rst low SHALL immediately force: FSM IDLE, tag queue empty, beat counter 0, last-granted = requester 1, rdf_orphan 0, registered outputs 0.
REQ-028 Reset mid-operation SHALL discard outstanding tags; the bench/system resets the DDR FIFOs concurrently.

Verification
REQ-029 Single: r0_valid=1, r0_addr=31'h10400000, af_full=0 -> af_wr_en next cycle with af_addr_din=31'h10400000, r0_ack pulse; two rdf beats (128'hff000000ceaa0e3ddeadbeefffffffff, 128'h0) -> r0_rd_valid on both, rdf_rd_en on both, busy low afterwards.
REQ-030 Contention: r0 and r1 held valid, 4 grants -> order r0, r1, r0, r1; returned beats route 2,2,2,2 in the same order.
REQ-031 Backpressure: af_full=1 for 5 cycles during ISSUE -> af_wr_en low, af_addr_din stable, no ack; af_full=0 -> ack in that cycle.
REQ-032 Full: 4 requests issued with no rdf data -> 5th request never acked; one request's 2 beats returned -> 5th acked within 3 cycles.
REQ-033 Orphan: rdf_valid=1 with empty queue -> rdf_rd_en=0, no rd_valid, rdf_orphan=1 held until rst low.
REQ-034 Reset: rst low with 3 outstanding and mid-beat -> busy=0, queue empty, beat counter 0 immediately; first grant after release goes to r0.
